// File: rtl/class_result_decoder_pkg.sv
// Shared constants, state encoding and configuration check for class_result_decoder.
package class_result_decoder_pkg;

    localparam int unsigned FP32_W          = 32;
    localparam logic [7:0]  FP32_NAN_EXP    = 8'hFF;
    localparam logic [31:0] CONF_THRESH_DEF = 32'h3F00_0000;  // 0.5
    localparam int unsigned NUM_CLASS_DEF   = 7;
    localparam int unsigned IDX_W_DEF       = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Legal configuration: 2..16 classes, index exactly clog2(NUM_CLASS) wide, fp32 scores.
    function automatic bit cfg_ok(int unsigned data_w, int unsigned num_class, int unsigned idx_w);
        return (data_w == FP32_W) && (num_class >= 2) && (num_class <= 16) &&
               (idx_w == $clog2(num_class));
    endfunction

endpackage

// File: rtl/class_result_decoder_if.sv
// Score-vector input and decoded-result output of the classifier readout.
// slave : the decoder (consumes Data_In/Valid_In/Ready_Out/Clr_Ovf, drives the result).
// master: the producer/host side.
interface class_result_if
    import class_result_decoder_pkg::*;
#(
    parameter int unsigned DATA_WIDHT = FP32_W,
    parameter int unsigned NUM_CLASS  = NUM_CLASS_DEF,
    parameter int unsigned IDX_W      = IDX_W_DEF
);
    logic [DATA_WIDHT*NUM_CLASS-1:0] Data_In;
    logic                            Valid_In;
    logic                            Ready_Out;
    logic                            Clr_Ovf;
    logic [IDX_W-1:0]                Class_Idx;
    logic [DATA_WIDHT-1:0]           Class_Score;
    logic                            Low_Conf;
    logic                            Valid_Out;
    logic                            Busy;
    logic                            Overflow;

    modport slave (
        input  Data_In, Valid_In, Ready_Out, Clr_Ovf,
        output Class_Idx, Class_Score, Low_Conf, Valid_Out, Busy, Overflow
    );

    modport master (
        output Data_In, Valid_In, Ready_Out, Clr_Ovf,
        input  Class_Idx, Class_Score, Low_Conf, Valid_Out, Busy, Overflow
    );
endinterface

// File: rtl/class_result_decoder_fp32_greater.sv
// Combinational fp32 "a > b": sign-magnitude compare, +0 == -0, any NaN gives 0.
// Ports: a, b (fp32 operands), gt (1 when a is strictly greater than b).
module fp32_greater
    import class_result_decoder_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic              gt
);
    logic a_nan;
    logic b_nan;
    logic both_zero;

    assign a_nan     = (a[30:23] == FP32_NAN_EXP) && (a[22:0] != 23'd0);
    assign b_nan     = (b[30:23] == FP32_NAN_EXP) && (b[22:0] != 23'd0);
    assign both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);

    always_comb begin
        gt = 1'b0;
        if (!(a_nan || b_nan || both_zero)) begin
            case ({a[31], b[31]})
                2'b00:   gt = (a[30:0] > b[30:0]);
                2'b01:   gt = 1'b1;
                2'b10:   gt = 1'b0;
                default: gt = (a[30:0] < b[30:0]);  // both negative: smaller magnitude wins
            endcase
        end
    end
endmodule

// File: rtl/class_result_decoder.sv
// Captures a softmax score vector on a one-cycle pulse, runs a sequential argmax
// (one compare per cycle) and holds class index / score / low-confidence flag
// under a valid/ready handshake.
// Ports: clk, rst (async active-low), bus (class_result_if.slave: Data_In, Valid_In,
// Ready_Out, Clr_Ovf in; Class_Idx, Class_Score, Low_Conf, Valid_Out, Busy, Overflow out).
module class_result_decoder
    import class_result_decoder_pkg::*;
#(
    parameter int unsigned DATA_WIDHT  = FP32_W,
    parameter int unsigned NUM_CLASS   = NUM_CLASS_DEF,
    parameter int unsigned IDX_W       = IDX_W_DEF,
    parameter logic [31:0] CONF_THRESH = CONF_THRESH_DEF
)(
    input  logic           clk,
    input  logic           rst,
    class_result_if.slave  bus
);
    if (!cfg_ok(DATA_WIDHT, NUM_CLASS, IDX_W)) begin : g_cfg_err
        $error("class_result_decoder: illegal DATA_WIDHT/NUM_CLASS/IDX_W combination");
    end

    state_e                state_q, state_d;
    logic [DATA_WIDHT-1:0] score_q [NUM_CLASS];
    logic [DATA_WIDHT-1:0] best_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      cnt_q;

    logic [IDX_W-1:0]      res_idx_q;
    logic [DATA_WIDHT-1:0] res_score_q;
    logic                  low_conf_q;
    logic                  valid_out_q;
    logic                  busy_q;
    logic                  ovf_q;

    logic [DATA_WIDHT-1:0] cand_c;
    logic                  cand_gt_c;
    logic [DATA_WIDHT-1:0] best_next_c;
    logic [IDX_W-1:0]      idx_next_c;
    logic                  below_c;
    logic                  handshake_c;
    logic                  capture_c;
    logic                  drop_c;
    logic                  last_c;

    // Argmax step: the candidate must be strictly greater, so ties keep the lower index.
    assign cand_c = score_q[cnt_q];

    fp32_greater u_argmax_cmp (
        .a  (cand_c),
        .b  (best_q),
        .gt (cand_gt_c)
    );

    assign best_next_c = cand_gt_c ? cand_c : best_q;
    assign idx_next_c  = cand_gt_c ? cnt_q  : idx_q;

    // Threshold compare with swapped operands: best < CONF_THRESH.
    fp32_greater u_thresh_cmp (
        .a  (CONF_THRESH),
        .b  (best_next_c),
        .gt (below_c)
    );

    // Valid_Out is only ever high in HOLD, so this is the HOLD handshake.
    assign handshake_c = valid_out_q & bus.Ready_Out;
    assign capture_c   = bus.Valid_In & ((state_q == ST_IDLE) || handshake_c);
    assign drop_c      = bus.Valid_In & ~capture_c;
    assign last_c      = (state_q == ST_SCAN) && (cnt_q == IDX_W'(NUM_CLASS - 1));

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (capture_c) state_d = ST_SCAN;
            ST_SCAN: if (last_c)    state_d = ST_HOLD;
            ST_HOLD: if (handshake_c) state_d = bus.Valid_In ? ST_SCAN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Capture, scan datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(NUM_CLASS); k++) score_q[k] <= '0;
            best_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            res_idx_q   <= '0;
            res_score_q <= '0;
            low_conf_q  <= 1'b0;
            valid_out_q <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (capture_c) begin
                for (int k = 0; k < int'(NUM_CLASS); k++)
                    score_q[k] <= bus.Data_In[k*DATA_WIDHT +: DATA_WIDHT];
                best_q <= bus.Data_In[DATA_WIDHT-1:0];
                idx_q  <= '0;
                cnt_q  <= IDX_W'(1);
            end else if (state_q == ST_SCAN) begin
                best_q <= best_next_c;
                idx_q  <= idx_next_c;
                if (!last_c) cnt_q <= IDX_W'(cnt_q + IDX_W'(1));
            end

            if (last_c) begin
                res_idx_q   <= idx_next_c;
                res_score_q <= best_next_c;
                low_conf_q  <= below_c;
            end

            valid_out_q <= (state_d == ST_HOLD);
            busy_q      <= (state_d != ST_IDLE);

            // Set wins over clear.
            if (drop_c)           ovf_q <= 1'b1;
            else if (bus.Clr_Ovf) ovf_q <= 1'b0;
        end
    end

    assign bus.Class_Idx   = res_idx_q;
    assign bus.Class_Score = res_score_q;
    assign bus.Low_Conf    = low_conf_q;
    assign bus.Valid_Out   = valid_out_q;
    assign bus.Busy        = busy_q;
    assign bus.Overflow    = ovf_q;

endmodule

// File: tb/tb_class_result_decoder.sv
// Directed bench for class_result_decoder with a scoreboard-driven result monitor.
module tb_class_result_decoder;

    logic clk;
    logic rst;

    class_result_if #(.DATA_WIDHT(32), .NUM_CLASS(7), .IDX_W(3)) bus ();

    class_result_decoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] score;
        logic        low;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Class 0 in the least significant word.
    localparam logic [223:0] V1 = {32'h3C23D70A, 32'h3CA3D70A, 32'h3CA3D70A, 32'h3D4CCCCD,
                                   32'h3F333333, 32'h3DCCCCCD, 32'h3DCCCCCD};
    localparam logic [223:0] V2 = {7{32'h3E800000}};
    localparam logic [223:0] V3 = {32'hC0800000, 32'hC0400000, 32'hBF000000, 32'h7FC00000,
                                   32'hC0000000, 32'hBF000000, 32'hBF800000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [2:0] idx, input logic [31:0] score, input logic low);
        exp_t e;
        e.idx = idx; e.score = score; e.low = low;
        sb.push_back(e);
    endtask

    // Called just after a rising edge; Valid_In is high for exactly one cycle.
    task automatic pulse(input logic [223:0] v);
        bus.Data_In  = v;
        bus.Valid_In = 1'b1;
        @(posedge clk); #1;
        bus.Valid_In = 1'b0;
        bus.Data_In  = '0;
    endtask

    // Counts rising edges until Valid_Out is seen, bounded.
    task automatic wait_valid(input int exp_lat);
        int lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.Valid_Out && lat < 20);
        check("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.Valid_Out), 32'd0);
        check({tag, "_busy"},  32'(bus.Busy),      32'd0);
        check({tag, "_idx"},   32'(bus.Class_Idx), 32'd0);
        check({tag, "_score"}, bus.Class_Score,    32'd0);
        check({tag, "_low"},   32'(bus.Low_Conf),  32'd0);
        check({tag, "_ovf"},   32'(bus.Overflow),  32'd0);
    endtask

    // Monitor: every handshake retires one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.Valid_Out && bus.Ready_Out) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_result: got idx %0d score %h, expected none",
                             bus.Class_Idx, bus.Class_Score);
                end else begin
                    e = sb.pop_front();
                    check("class_idx",   32'(bus.Class_Idx), 32'(e.idx));
                    check("class_score", bus.Class_Score,    e.score);
                    check("low_conf",    32'(bus.Low_Conf),  32'(e.low));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.Data_In   = '0;
        bus.Valid_In  = 1'b0;
        bus.Ready_Out = 1'b0;
        bus.Clr_Ovf   = 1'b0;
        #1 rst = 1'b0;
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Clear winner, then single-cycle handshake.
        push_exp(3'd2, 32'h3F333333, 1'b0);
        pulse(V1);
        wait_valid(6);
        check("busy_hold", 32'(bus.Busy), 32'd1);
        bus.Ready_Out = 1'b1;
        @(posedge clk); #1;
        bus.Ready_Out = 1'b0;
        check("valid_drop", 32'(bus.Valid_Out), 32'd0);
        check("busy_idle",  32'(bus.Busy),      32'd0);

        // All equal: tie to index 0, below threshold.
        push_exp(3'd0, 32'h3E800000, 1'b1);
        pulse(V2);
        wait_valid(6);
        bus.Ready_Out = 1'b1;
        @(posedge clk); #1;
        bus.Ready_Out = 1'b0;

        // Negatives, NaN and a later tie.
        push_exp(3'd1, 32'hBF000000, 1'b1);
        pulse(V3);
        wait_valid(6);
        bus.Ready_Out = 1'b1;
        @(posedge clk); #1;
        bus.Ready_Out = 1'b0;

        // Dropped pulses during SCAN and HOLD, then overflow clear.
        push_exp(3'd2, 32'h3F333333, 1'b0);
        pulse(V1);
        repeat (2) @(posedge clk);
        #1;
        pulse(V3);
        check("ovf_scan_drop", 32'(bus.Overflow), 32'd1);
        wait_valid(3);
        pulse(V2);
        check("ovf_hold_drop", 32'(bus.Overflow),  32'd1);
        check("hold_valid",    32'(bus.Valid_Out), 32'd1);
        bus.Clr_Ovf = 1'b1;
        pulse(V2);
        bus.Clr_Ovf = 1'b0;
        check("ovf_set_wins", 32'(bus.Overflow), 32'd1);
        bus.Clr_Ovf = 1'b1;
        @(posedge clk); #1;
        bus.Clr_Ovf = 1'b0;
        check("ovf_cleared", 32'(bus.Overflow), 32'd0);
        bus.Ready_Out = 1'b1;
        @(posedge clk); #1;
        bus.Ready_Out = 1'b0;
        check("valid_drop2", 32'(bus.Valid_Out), 32'd0);

        // Back-to-back capture in the handshake cycle.
        bus.Ready_Out = 1'b1;
        push_exp(3'd1, 32'hBF000000, 1'b1);
        pulse(V3);
        wait_valid(6);
        push_exp(3'd2, 32'h3F333333, 1'b0);
        pulse(V1);
        check("b2b_ovf",  32'(bus.Overflow), 32'd0);
        check("b2b_busy", 32'(bus.Busy),     32'd1);
        wait_valid(6);
        check("b2b_ovf2", 32'(bus.Overflow), 32'd0);
        @(posedge clk); #1;
        bus.Ready_Out = 1'b0;

        // Asynchronous reset three cycles into SCAN.
        pulse(V2);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_all_zero("abort");
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.Ready_Out = 1'b1;
        push_exp(3'd0, 32'h3E800000, 1'b1);
        pulse(V2);
        wait_valid(6);
        @(posedge clk); #1;
        bus.Ready_Out = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
